// File: rtl/mem_access_unit_if.sv
// Data-memory valid/ready bus between the MEM-stage master and the memory.
interface mem_access_unit_if;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req_valid, dmem_addr, dmem_we, dmem_wstrb, dmem_wdata,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rdata
  );

  modport slave (
    input  dmem_req_valid, dmem_addr, dmem_we, dmem_wstrb, dmem_wdata,
    output dmem_req_ready, dmem_rsp_valid, dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory master: issues loads/stores, stalls while in flight, registers MEM/WB results.
// Optional bus watchdog enabled by defining DMEM_TIMEOUT_EN (TIMEOUT_CYCLES parameter exists only then).
module mem_access_unit
`ifdef DMEM_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 255)
`endif
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       alu_result_mem,
  input  logic [31:0]       rs2_data_mem,
  input  logic [4:0]        rd_mem,
  input  logic              mem_write_mem,
  input  logic [2:0]        mem_load_type_mem,
  input  logic [1:0]        mem_store_type_mem,
  input  logic              wb_reg_file_mem,
  input  logic              memtoreg_mem,
  mem_access_unit_if.master dmem,
  output logic              mem_stall,
  output logic              misalign_fault,
  output logic              bus_timeout,
  output logic [31:0]       alu_result_wb,
  output logic [31:0]       load_data_wb,
  output logic [4:0]        rd_wb,
  output logic              wb_reg_file_wb,
  output logic              memtoreg_wb
);

  localparam logic [2:0] LD_LB  = 3'd0;
  localparam logic [2:0] LD_LH  = 3'd1;
  localparam logic [2:0] LD_LW  = 3'd2;
  localparam logic [2:0] LD_LBU = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;
  localparam logic [1:0] ST_SB  = 2'd0;
  localparam logic [1:0] ST_SH  = 2'd1;
  localparam logic [1:0] ST_SW  = 2'd2;
  localparam logic [1:0] ST_NONE = 2'd3;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  state_e      state_q, state_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misalign_q, misalign_d;
  logic [31:0] alu_wb_q, alu_wb_d;
  logic [31:0] load_wb_q, load_wb_d;
  logic [4:0]  rd_wb_q, rd_wb_d;
  logic        wb_en_q, wb_en_d;
  logic        memtoreg_wb_q, memtoreg_wb_d;

  logic        is_load_c, is_store_c, half_c, word_c, misaligned_c, start_c, hs_c, stall_c;
  logic [1:0]  ofs_c;
  logic [3:0]  wstrb_c;
  logic [31:0] wdata_c, load_fmt_c;
  logic [7:0]  rbyte_c;
  logic [15:0] rhalf_c;

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timed_out_q, timed_out_d;
  logic             timeout_q, timeout_d;
`endif

  // Access decode, alignment check, store lane steering and load formatting
  always_comb begin
    ofs_c        = alu_result_mem[1:0];
    is_load_c    = memtoreg_mem && (mem_load_type_mem <= LD_LHU);
    is_store_c   = mem_write_mem && (mem_store_type_mem != ST_NONE) && !is_load_c;
    half_c       = (is_load_c && (mem_load_type_mem == LD_LH || mem_load_type_mem == LD_LHU)) ||
                   (is_store_c && mem_store_type_mem == ST_SH);
    word_c       = (is_load_c && mem_load_type_mem == LD_LW) ||
                   (is_store_c && mem_store_type_mem == ST_SW);
    misaligned_c = (half_c && ofs_c[0]) || (word_c && (ofs_c != 2'b00));
    start_c      = (is_load_c || is_store_c) && !misaligned_c;

    wstrb_c = 4'b0000;
    wdata_c = '0;
    if (is_store_c) begin
      case (mem_store_type_mem)
        ST_SB: begin
          wstrb_c = 4'b0001 << ofs_c;
          wdata_c = {4{rs2_data_mem[7:0]}};
        end
        ST_SH: begin
          wstrb_c = 4'b0011 << ofs_c;
          wdata_c = {2{rs2_data_mem[15:0]}};
        end
        default: begin
          wstrb_c = 4'b1111;
          wdata_c = rs2_data_mem;
        end
      endcase
    end

    rbyte_c = 8'(dmem.dmem_rdata >> {ofs_c, 3'b000});
    rhalf_c = ofs_c[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (mem_load_type_mem)
      LD_LB:   load_fmt_c = {{24{rbyte_c[7]}}, rbyte_c};
      LD_LH:   load_fmt_c = {{16{rhalf_c[15]}}, rhalf_c};
      LD_LW:   load_fmt_c = dmem.dmem_rdata;
      LD_LBU:  load_fmt_c = {24'd0, rbyte_c};
      LD_LHU:  load_fmt_c = {16'd0, rhalf_c};
      default: load_fmt_c = '0;
    endcase
  end

  // Next-state and register-input logic
  always_comb begin
    state_d       = state_q;
    req_valid_d   = req_valid_q;
    addr_d        = addr_q;
    we_d          = we_q;
    wstrb_d       = wstrb_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    misalign_d    = 1'b0;
    alu_wb_d      = alu_wb_q;
    load_wb_d     = load_wb_q;
    rd_wb_d       = rd_wb_q;
    wb_en_d       = 1'b0;
    memtoreg_wb_d = 1'b0;
    stall_c       = 1'b0;
    hs_c          = req_valid_q && dmem.dmem_req_ready;
`ifdef DMEM_TIMEOUT_EN
    cnt_d         = cnt_q;
    timed_out_d   = timed_out_q;
    timeout_d     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (start_c) begin
          stall_c     = 1'b1;
          state_d     = REQ;
          req_valid_d = 1'b1;
          addr_d      = {alu_result_mem[31:2], 2'b00};
          we_d        = is_store_c;
          wstrb_d     = wstrb_c;
          wdata_d     = wdata_c;
          rdata_d     = '0;
`ifdef DMEM_TIMEOUT_EN
          cnt_d       = '0;
          timed_out_d = 1'b0;
`endif
        end else begin
          misalign_d    = misaligned_c;
          alu_wb_d      = alu_result_mem;
          rd_wb_d       = rd_mem;
          wb_en_d       = wb_reg_file_mem && !misaligned_c;
          memtoreg_wb_d = memtoreg_mem;
          load_wb_d     = '0;
        end
      end
      REQ: begin
        stall_c = 1'b1;
        if (hs_c) begin
          state_d     = we_q ? DONE : RESP;
          req_valid_d = 1'b0;
          addr_d      = '0;
          we_d        = 1'b0;
          wstrb_d     = '0;
          wdata_d     = '0;
        end
      end
      RESP: begin
        stall_c = 1'b1;
        if (dmem.dmem_rsp_valid) begin
          rdata_d = load_fmt_c;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d       = IDLE;
        alu_wb_d      = alu_result_mem;
        rd_wb_d       = rd_mem;
`ifdef DMEM_TIMEOUT_EN
        wb_en_d       = wb_reg_file_mem && !timed_out_q;
`else
        wb_en_d       = wb_reg_file_mem;
`endif
        memtoreg_wb_d = memtoreg_mem;
        load_wb_d     = rdata_q;
      end
      default: state_d = IDLE;
    endcase

`ifdef DMEM_TIMEOUT_EN
    // Watchdog saturates at the limit so a late handshake cannot wrap it
    if (state_q == REQ || state_q == RESP) begin
      cnt_d = (cnt_q == CNT_W'(TIMEOUT_CYCLES)) ? cnt_q : cnt_q + CNT_W'(1);
      if (state_d == state_q && cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
        state_d     = DONE;
        timeout_d   = 1'b1;
        timed_out_d = 1'b1;
        req_valid_d = 1'b0;
        addr_d      = '0;
        we_d        = 1'b0;
        wstrb_d     = '0;
        wdata_d     = '0;
      end
    end
`endif

    mem_stall = stall_c && rst;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      req_valid_q   <= 1'b0;
      addr_q        <= '0;
      we_q          <= 1'b0;
      wstrb_q       <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      misalign_q    <= 1'b0;
      alu_wb_q      <= '0;
      load_wb_q     <= '0;
      rd_wb_q       <= '0;
      wb_en_q       <= 1'b0;
      memtoreg_wb_q <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      cnt_q         <= '0;
      timed_out_q   <= 1'b0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      req_valid_q   <= req_valid_d;
      addr_q        <= addr_d;
      we_q          <= we_d;
      wstrb_q       <= wstrb_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      misalign_q    <= misalign_d;
      alu_wb_q      <= alu_wb_d;
      load_wb_q     <= load_wb_d;
      rd_wb_q       <= rd_wb_d;
      wb_en_q       <= wb_en_d;
      memtoreg_wb_q <= memtoreg_wb_d;
`ifdef DMEM_TIMEOUT_EN
      cnt_q         <= cnt_d;
      timed_out_q   <= timed_out_d;
      timeout_q     <= timeout_d;
`endif
    end
  end

  assign dmem.dmem_req_valid = req_valid_q;
  assign dmem.dmem_addr      = addr_q;
  assign dmem.dmem_we        = we_q;
  assign dmem.dmem_wstrb     = wstrb_q;
  assign dmem.dmem_wdata     = wdata_q;
  assign misalign_fault      = misalign_q;
  assign alu_result_wb       = alu_wb_q;
  assign load_data_wb        = load_wb_q;
  assign rd_wb               = rd_wb_q;
  assign wb_reg_file_wb      = wb_en_q;
  assign memtoreg_wb         = memtoreg_wb_q;
`ifdef DMEM_TIMEOUT_EN
  assign bus_timeout         = timeout_q;
`else
  assign bus_timeout         = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit; watchdog scenario runs when DMEM_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result_mem, rs2_data_mem;
  logic [4:0]  rd_mem;
  logic        mem_write_mem;
  logic [2:0]  mem_load_type_mem;
  logic [1:0]  mem_store_type_mem;
  logic        wb_reg_file_mem, memtoreg_mem;
  logic        mem_stall, misalign_fault, bus_timeout;
  logic [31:0] alu_result_wb, load_data_wb;
  logic [4:0]  rd_wb;
  logic        wb_reg_file_wb, memtoreg_wb;

  int checks   = 0;
  int failures = 0;

  logic [31:0] st_addr  [3] = '{32'h0000_1003, 32'h0000_1002, 32'h0000_1004};
  logic [1:0]  st_type  [3] = '{2'b00, 2'b01, 2'b10};
  logic [31:0] st_eaddr [3] = '{32'h0000_1000, 32'h0000_1000, 32'h0000_1004};
  logic [3:0]  st_strb  [3] = '{4'b1000, 4'b1100, 4'b1111};
  logic [31:0] st_data  [3] = '{32'hDDDD_DDDD, 32'hCCDD_CCDD, 32'hAABB_CCDD};

  mem_access_unit_if dmem_bus();

`ifdef DMEM_TIMEOUT_EN
  mem_access_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk                (clk),
    .rst                (rst),
    .alu_result_mem     (alu_result_mem),
    .rs2_data_mem       (rs2_data_mem),
    .rd_mem             (rd_mem),
    .mem_write_mem      (mem_write_mem),
    .mem_load_type_mem  (mem_load_type_mem),
    .mem_store_type_mem (mem_store_type_mem),
    .wb_reg_file_mem    (wb_reg_file_mem),
    .memtoreg_mem       (memtoreg_mem),
    .dmem               (dmem_bus),
    .mem_stall          (mem_stall),
    .misalign_fault     (misalign_fault),
    .bus_timeout        (bus_timeout),
    .alu_result_wb      (alu_result_wb),
    .load_data_wb       (load_data_wb),
    .rd_wb              (rd_wb),
    .wb_reg_file_wb     (wb_reg_file_wb),
    .memtoreg_wb        (memtoreg_wb)
  );
`else
  mem_access_unit dut (
    .clk                (clk),
    .rst                (rst),
    .alu_result_mem     (alu_result_mem),
    .rs2_data_mem       (rs2_data_mem),
    .rd_mem             (rd_mem),
    .mem_write_mem      (mem_write_mem),
    .mem_load_type_mem  (mem_load_type_mem),
    .mem_store_type_mem (mem_store_type_mem),
    .wb_reg_file_mem    (wb_reg_file_mem),
    .memtoreg_mem       (memtoreg_mem),
    .dmem               (dmem_bus),
    .mem_stall          (mem_stall),
    .misalign_fault     (misalign_fault),
    .bus_timeout        (bus_timeout),
    .alu_result_wb      (alu_result_wb),
    .load_data_wb       (load_data_wb),
    .rd_wb              (rd_wb),
    .wb_reg_file_wb     (wb_reg_file_wb),
    .memtoreg_wb        (memtoreg_wb)
  );
`endif

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    alu_result_mem     = '0;
    rs2_data_mem       = '0;
    rd_mem             = '0;
    mem_write_mem      = 1'b0;
    mem_load_type_mem  = 3'b111;
    mem_store_type_mem = 2'b11;
    wb_reg_file_mem    = 1'b0;
    memtoreg_mem       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    alu_result_mem = 32'h0000_0100; rs2_data_mem = 32'h1234_5678; rd_mem = 5'd3;
    mem_write_mem = 1'b1; mem_store_type_mem = 2'b10; wb_reg_file_mem = 1'b1;
    dmem_bus.dmem_req_ready = 1'b1;
    tick(); tick();
    checks++; if (mem_stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", mem_stall); end
    checks++; if (dmem_bus.dmem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid: got %b expected 0", dmem_bus.dmem_req_valid); end
    checks++; if (dmem_bus.dmem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h expected 0", dmem_bus.dmem_addr); end
    checks++; if (dmem_bus.dmem_wstrb !== 4'h0) begin failures++; $display("FAIL reset_wstrb: got %b expected 0000", dmem_bus.dmem_wstrb); end
    checks++; if (alu_result_wb !== 32'h0) begin failures++; $display("FAIL reset_alu_wb: got %h expected 0", alu_result_wb); end
    checks++; if (wb_reg_file_wb !== 1'b0) begin failures++; $display("FAIL reset_wb_en: got %b expected 0", wb_reg_file_wb); end
    checks++; if (misalign_fault !== 1'b0 || bus_timeout !== 1'b0) begin failures++; $display("FAIL reset_faults: got %b%b expected 00", misalign_fault, bus_timeout); end
    set_idle();
    dmem_bus.dmem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    alu_result_mem = 32'h0000_1234; rd_mem = 5'd5; wb_reg_file_mem = 1'b1;
    #1;
    checks++; if (mem_stall !== 1'b0) begin failures++; $display("FAIL alu_stall: got %b expected 0", mem_stall); end
    checks++; if (dmem_bus.dmem_req_valid !== 1'b0) begin failures++; $display("FAIL alu_req_valid: got %b expected 0", dmem_bus.dmem_req_valid); end
    tick();
    checks++; if (alu_result_wb !== 32'h0000_1234) begin failures++; $display("FAIL alu_result_wb: got %h expected 00001234", alu_result_wb); end
    checks++; if (rd_wb !== 5'd5 || wb_reg_file_wb !== 1'b1) begin failures++; $display("FAIL alu_rd_wb: got %0d/%b expected 5/1", rd_wb, wb_reg_file_wb); end
    checks++; if (load_data_wb !== 32'h0) begin failures++; $display("FAIL alu_load_data: got %h expected 0", load_data_wb); end
    set_idle();
  endtask

  task automatic test_back_to_back_stores();
    dmem_bus.dmem_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_idle();
      alu_result_mem = st_addr[i]; rs2_data_mem = 32'hAABB_CCDD; rd_mem = 5'd1;
      mem_write_mem = 1'b1; mem_store_type_mem = st_type[i];
      #1;
      checks++; if (mem_stall !== 1'b1 || dmem_bus.dmem_req_valid !== 1'b0) begin failures++; $display("FAIL st%0d_idle: stall=%b valid=%b expected 1/0", i, mem_stall, dmem_bus.dmem_req_valid); end
      tick();
      checks++; if (dmem_bus.dmem_req_valid !== 1'b1 || mem_stall !== 1'b1) begin failures++; $display("FAIL st%0d_req: valid=%b stall=%b expected 1/1", i, dmem_bus.dmem_req_valid, mem_stall); end
      checks++; if (dmem_bus.dmem_addr !== st_eaddr[i] || dmem_bus.dmem_we !== 1'b1) begin failures++; $display("FAIL st%0d_addr: got %h/%b expected %h/1", i, dmem_bus.dmem_addr, dmem_bus.dmem_we, st_eaddr[i]); end
      checks++; if (dmem_bus.dmem_wstrb !== st_strb[i]) begin failures++; $display("FAIL st%0d_wstrb: got %b expected %b", i, dmem_bus.dmem_wstrb, st_strb[i]); end
      checks++; if (dmem_bus.dmem_wdata !== st_data[i]) begin failures++; $display("FAIL st%0d_wdata: got %h expected %h", i, dmem_bus.dmem_wdata, st_data[i]); end
      tick();
      checks++; if (mem_stall !== 1'b0 || dmem_bus.dmem_req_valid !== 1'b0) begin failures++; $display("FAIL st%0d_done: stall=%b valid=%b expected 0/0", i, mem_stall, dmem_bus.dmem_req_valid); end
      tick();
      checks++; if (alu_result_wb !== st_addr[i] || wb_reg_file_wb !== 1'b0) begin failures++; $display("FAIL st%0d_wb: got %h/%b expected %h/0", i, alu_result_wb, wb_reg_file_wb, st_addr[i]); end
    end
    dmem_bus.dmem_req_ready = 1'b0;
    set_idle();
  endtask

  task automatic test_load(input string nm, input logic [2:0] ltype, input logic [31:0] addr,
                           input logic [31:0] rdata, input int rdy_dly, input int rsp_dly,
                           input logic [31:0] exp);
    set_idle();
    alu_result_mem = addr; rd_mem = 5'd9; wb_reg_file_mem = 1'b1;
    memtoreg_mem = 1'b1; mem_load_type_mem = ltype;
    dmem_bus.dmem_req_ready = 1'b0; dmem_bus.dmem_rsp_valid = 1'b0;
    dmem_bus.dmem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (mem_stall !== 1'b1) begin failures++; $display("FAIL %s_idle_stall: got %b expected 1", nm, mem_stall); end
    tick();
    for (int i = 0; i < rdy_dly; i++) begin
      checks++; if (dmem_bus.dmem_req_valid !== 1'b1 || mem_stall !== 1'b1) begin failures++; $display("FAIL %s_wait%0d: valid=%b stall=%b expected 1/1", nm, i, dmem_bus.dmem_req_valid, mem_stall); end
      tick();
    end
    dmem_bus.dmem_req_ready = 1'b1;
    checks++; if (dmem_bus.dmem_addr !== {addr[31:2], 2'b00} || dmem_bus.dmem_we !== 1'b0 || dmem_bus.dmem_wstrb !== 4'b0000) begin failures++; $display("FAIL %s_req: addr=%h we=%b strb=%b expected %h/0/0000", nm, dmem_bus.dmem_addr, dmem_bus.dmem_we, dmem_bus.dmem_wstrb, {addr[31:2], 2'b00}); end
    tick();
    dmem_bus.dmem_req_ready = 1'b0;
    checks++; if (dmem_bus.dmem_req_valid !== 1'b0 || mem_stall !== 1'b1) begin failures++; $display("FAIL %s_resp: valid=%b stall=%b expected 0/1", nm, dmem_bus.dmem_req_valid, mem_stall); end
    for (int k = 1; k <= rsp_dly; k++) begin
      dmem_bus.dmem_rsp_valid = (k == rsp_dly);
      dmem_bus.dmem_rdata = (k == rsp_dly) ? rdata : 32'hDEAD_BEEF;
      tick();
    end
    dmem_bus.dmem_rsp_valid = 1'b0;
    dmem_bus.dmem_rdata = 32'hDEAD_BEEF;
    checks++; if (mem_stall !== 1'b0) begin failures++; $display("FAIL %s_done_stall: got %b expected 0", nm, mem_stall); end
    tick();
    checks++; if (load_data_wb !== exp) begin failures++; $display("FAIL %s_data: got %h expected %h", nm, load_data_wb, exp); end
    checks++; if (wb_reg_file_wb !== 1'b1 || memtoreg_wb !== 1'b1 || rd_wb !== 5'd9) begin failures++; $display("FAIL %s_ctl: got %b/%b/%0d expected 1/1/9", nm, wb_reg_file_wb, memtoreg_wb, rd_wb); end
    set_idle();
  endtask

  task automatic test_misalign();
    alu_result_mem = 32'h0000_2002; rd_mem = 5'd4; wb_reg_file_mem = 1'b1;
    memtoreg_mem = 1'b1; mem_load_type_mem = 3'b010;
    #1;
    checks++; if (mem_stall !== 1'b0) begin failures++; $display("FAIL mis_lw_stall: got %b expected 0", mem_stall); end
    tick();
    checks++; if (misalign_fault !== 1'b1 || wb_reg_file_wb !== 1'b0) begin failures++; $display("FAIL mis_lw_fault: got %b/%b expected 1/0", misalign_fault, wb_reg_file_wb); end
    checks++; if (dmem_bus.dmem_req_valid !== 1'b0) begin failures++; $display("FAIL mis_lw_req: got %b expected 0", dmem_bus.dmem_req_valid); end
    set_idle();
    alu_result_mem = 32'h0000_3001; mem_write_mem = 1'b1; mem_store_type_mem = 2'b01;
    #1;
    checks++; if (mem_stall !== 1'b0) begin failures++; $display("FAIL mis_sh_stall: got %b expected 0", mem_stall); end
    tick();
    checks++; if (misalign_fault !== 1'b1 || dmem_bus.dmem_req_valid !== 1'b0) begin failures++; $display("FAIL mis_sh_fault: got %b/%b expected 1/0", misalign_fault, dmem_bus.dmem_req_valid); end
    set_idle();
    tick();
    checks++; if (misalign_fault !== 1'b0) begin failures++; $display("FAIL mis_pulse: got %b expected 0", misalign_fault); end
  endtask

  task automatic test_reset_mid_resp();
    alu_result_mem = 32'h0000_55AA; rd_mem = 5'd7; wb_reg_file_mem = 1'b1;
    tick();
    set_idle();
    alu_result_mem = 32'h0000_3000; rd_mem = 5'd8; memtoreg_mem = 1'b1; mem_load_type_mem = 3'b010;
    dmem_bus.dmem_req_ready = 1'b1;
    tick();
    tick();
    dmem_bus.dmem_req_ready = 1'b0;
    checks++; if (mem_stall !== 1'b1 || alu_result_wb !== 32'h0000_55AA) begin failures++; $display("FAIL rstm_pre: stall=%b alu_wb=%h expected 1/000055aa", mem_stall, alu_result_wb); end
    rst = 1'b0;
    #1;
    checks++; if (mem_stall !== 1'b0 || dmem_bus.dmem_req_valid !== 1'b0) begin failures++; $display("FAIL rstm_bus: stall=%b valid=%b expected 0/0", mem_stall, dmem_bus.dmem_req_valid); end
    checks++; if (alu_result_wb !== 32'h0 || rd_wb !== 5'd0 || load_data_wb !== 32'h0) begin failures++; $display("FAIL rstm_wb: got %h/%0d/%h expected 0/0/0", alu_result_wb, rd_wb, load_data_wb); end
    set_idle();
    tick();
    rst = 1'b1;
    dmem_bus.dmem_rsp_valid = 1'b1; dmem_bus.dmem_rdata = 32'hCAFE_F00D;
    tick();
    tick();
    dmem_bus.dmem_rsp_valid = 1'b0;
    checks++; if (mem_stall !== 1'b0 || dmem_bus.dmem_req_valid !== 1'b0) begin failures++; $display("FAIL rstm_idle: stall=%b valid=%b expected 0/0", mem_stall, dmem_bus.dmem_req_valid); end
    checks++; if (load_data_wb !== 32'h0) begin failures++; $display("FAIL rstm_late_rsp: got %h expected 0", load_data_wb); end
  endtask

`ifdef DMEM_TIMEOUT_EN
  task automatic test_timeout();
    alu_result_mem = 32'h0000_0040; rs2_data_mem = 32'h1; rd_mem = 5'd2; wb_reg_file_mem = 1'b1;
    mem_write_mem = 1'b1; mem_store_type_mem = 2'b10;
    dmem_bus.dmem_req_ready = 1'b0;
    tick();
    for (int i = 1; i <= 8; i++) begin
      checks++; if (dmem_bus.dmem_req_valid !== 1'b1 || bus_timeout !== 1'b0) begin failures++; $display("FAIL to_req%0d: valid=%b to=%b expected 1/0", i, dmem_bus.dmem_req_valid, bus_timeout); end
      tick();
    end
    checks++; if (bus_timeout !== 1'b1 || dmem_bus.dmem_req_valid !== 1'b0 || mem_stall !== 1'b0) begin failures++; $display("FAIL to_done: to=%b valid=%b stall=%b expected 1/0/0", bus_timeout, dmem_bus.dmem_req_valid, mem_stall); end
    tick();
    checks++; if (bus_timeout !== 1'b0 || wb_reg_file_wb !== 1'b0) begin failures++; $display("FAIL to_after: to=%b wb_en=%b expected 0/0", bus_timeout, wb_reg_file_wb); end
    set_idle();
  endtask
`else
  task automatic test_no_timeout();
    alu_result_mem = 32'h0000_0040; rs2_data_mem = 32'h1; rd_mem = 5'd2; wb_reg_file_mem = 1'b1;
    mem_write_mem = 1'b1; mem_store_type_mem = 2'b10;
    dmem_bus.dmem_req_ready = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    checks++; if (dmem_bus.dmem_req_valid !== 1'b1 || bus_timeout !== 1'b0 || mem_stall !== 1'b1) begin failures++; $display("FAIL nto_wait: valid=%b to=%b stall=%b expected 1/0/1", dmem_bus.dmem_req_valid, bus_timeout, mem_stall); end
    dmem_bus.dmem_req_ready = 1'b1;
    tick();
    dmem_bus.dmem_req_ready = 1'b0;
    checks++; if (mem_stall !== 1'b0) begin failures++; $display("FAIL nto_done: got %b expected 0", mem_stall); end
    tick();
    checks++; if (wb_reg_file_wb !== 1'b1) begin failures++; $display("FAIL nto_wb_en: got %b expected 1", wb_reg_file_wb); end
    set_idle();
  endtask
`endif

  initial begin
    rst = 1'b0;
    set_idle();
    dmem_bus.dmem_req_ready = 1'b0;
    dmem_bus.dmem_rsp_valid = 1'b0;
    dmem_bus.dmem_rdata     = '0;
    test_reset();
    test_alu();
    test_back_to_back_stores();
    test_load("lb",  3'b000, 32'h0000_2001, 32'h0000_80FF, 3, 2, 32'hFFFF_FF80);
    test_load("lbu", 3'b011, 32'h0000_2001, 32'h0000_80FF, 3, 2, 32'h0000_0080);
    test_load("lh",  3'b001, 32'h0000_2002, 32'h8001_0000, 1, 1, 32'hFFFF_8001);
    test_load("lhu", 3'b100, 32'h0000_2002, 32'h8001_0000, 0, 1, 32'h0000_8001);
    test_load("lw",  3'b010, 32'h0000_2000, 32'h1234_5678, 0, 3, 32'h1234_5678);
    test_misalign();
    test_reset_mid_resp();
`ifdef DMEM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
